// File: rtl/if_id_queue_pkg.sv
// Shared core defines: default datapath widths and the bubble/NOP constants.
package if_id_queue_pkg;

    localparam int unsigned CORE_PC_W   = 32;
    localparam int unsigned CORE_INST_W = 32;

    // A bubble presents an all-zero PC and an all-zero (NOP) instruction word
    localparam logic [CORE_PC_W-1:0]   ZERO_PC  = '0;
    localparam logic [CORE_INST_W-1:0] NOP_INST = '0;
    localparam logic                   ZERO_EXC = 1'b0;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for a power-of-two circular buffer.
module fifo_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_req_i,
    input  logic                       pop_req_i,
    output logic                       wr_en_c_o,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Flush wins over any same-cycle push or pop; full blocks push even when popping
    assign do_push   = push_req_i && !full_o  && !flush;
    assign do_pop    = pop_req_i  && !empty_o && !flush;
    assign wr_en_c_o = do_push;

    // Next pointers/count; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule : fifo_ctrl

// File: rtl/if_id_queue.sv
// Decoupling queue between fetch and decode; empty queue presents a zero bubble.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned PC_W   = CORE_PC_W,
    parameter int unsigned INST_W = CORE_INST_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic [INST_W-1:0]        inst_i,
    input  logic                     exc_i,
    output logic                     if_ready_o,
    input  logic                     id_stall,
    output logic                     id_valid_o,
    output logic [PC_W-1:0]          pc_o,
    output logic [INST_W-1:0]        inst_o,
    output logic                     exc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = PC_W + INST_W + 1;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en_c;
    logic             full;
    logic             empty;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_req_i (if_valid_i),
        .pop_req_i  (!id_stall),
        .wr_en_c_o  (wr_en_c),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count_o),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign if_ready_o = !full;
    assign id_valid_o = !empty;

    // Payload storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr] <= {exc_i, inst_i, pc_i};
        end
    end

    // Head view; stale storage is masked to a bubble whenever the queue is empty
    always_comb begin
        head   = mem_q[rd_ptr];
        pc_o   = PC_W'(ZERO_PC);
        inst_o = INST_W'(NOP_INST);
        exc_o  = ZERO_EXC;
        if (!empty) begin
            pc_o   = head[PC_W-1:0];
            inst_o = head[PC_W +: INST_W];
            exc_o  = head[ENT_W-1];
        end
    end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH = 4, 32-bit PC/instruction).
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        exc_i;
    logic        if_ready_o;
    logic        id_stall;
    logic        id_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    if_id_queue #(
        .PC_W   (32),
        .INST_W (32),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_valid_i (if_valid_i),
        .pc_i       (pc_i),
        .inst_i     (inst_i),
        .exc_i      (exc_i),
        .if_ready_o (if_ready_o),
        .id_stall   (id_stall),
        .id_valid_o (id_valid_o),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .exc_o      (exc_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic exc, input logic stall, input logic fl);
        if_valid_i = v;
        pc_i       = pc;
        inst_i     = inst;
        exc_i      = exc;
        id_stall   = stall;
        flush      = fl;
    endtask

    // Head view expected for a queue holding cnt entries with the given head PC
    task automatic expect_head(input string tag, input logic [31:0] pc, input int cnt);
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (cnt != 0) ? pc : 32'h0;
        e_inst = (cnt != 0) ? inst_of(pc) : 32'h0;
        check_eq({tag, ".cnt"},  64'(count_o),    64'(cnt));
        check_eq({tag, ".vld"},  64'(id_valid_o), 64'(cnt != 0));
        check_eq({tag, ".pc"},   64'(pc_o),       64'(e_pc));
        check_eq({tag, ".inst"}, 64'(inst_o),     64'(e_inst));
        check_eq({tag, ".rdy"},  64'(if_ready_o), 64'(cnt != 4));
    endtask

    initial begin
        // Reset held two cycles while IF keeps offering an entry
        rst = 1'b0;
        drive(1'b1, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expect_head("reset", 32'h0, 0);
        check_eq("reset.exc", 64'(exc_o), 64'(0));
        rst = 1'b1;

        // Fill under stall; head appears one cycle after first enqueue and holds
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), inst_of(32'h100 + 32'(4 * k)), 1'b0, 1'b1, 1'b0);
            tick();
            expect_head($sformatf("fill%0d", k), 32'h100, k + 1);
        end

        // Fifth enqueue while full is dropped
        drive(1'b1, 32'h110, inst_of(32'h110), 1'b0, 1'b1, 1'b0);
        tick();
        expect_head("fill_drop", 32'h100, 4);

        // Drain from full with 0x110 offered: blocked on the full edge, accepted next
        drive(1'b1, 32'h110, inst_of(32'h110), 1'b0, 1'b0, 1'b0);
        tick();
        expect_head("drain0", 32'h104, 3);
        tick();
        expect_head("drain1", 32'h108, 3);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_head("drain2", 32'h10C, 2);
        tick();
        expect_head("drain3", 32'h110, 1);
        tick();
        expect_head("drain_empty", 32'h0, 0);

        // Two entries, then enqueue+dequeue every cycle for 10 cycles
        drive(1'b1, 32'h300, inst_of(32'h300), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h304, inst_of(32'h304), 1'b0, 1'b1, 1'b0);
        tick();
        expect_head("conc_pre", 32'h300, 2);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * (k + 1)), inst_of(32'h300 + 32'(4 * (k + 1))),
                  1'b0, 1'b0, 1'b0);
            tick();
            expect_head($sformatf("conc%0d", k), 32'h300 + 32'(4 * k), 2);
        end

        // Grow to three entries, then flush with a same-edge enqueue and dequeue
        drive(1'b1, 32'h330, inst_of(32'h330), 1'b0, 1'b1, 1'b0);
        tick();
        expect_head("pre_flush", 32'h328, 3);
        drive(1'b1, 32'h340, inst_of(32'h340), 1'b0, 1'b0, 1'b1);
        tick();
        expect_head("flush", 32'h0, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_head("flush_idle", 32'h0, 0);
        drive(1'b1, 32'h200, inst_of(32'h200), 1'b0, 1'b1, 1'b0);
        tick();
        expect_head("post_flush", 32'h200, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_head("post_flush_drain", 32'h0, 0);

        // Exception tag follows its entry and clears once the queue empties
        drive(1'b1, 32'h400, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        tick();
        check_eq("exc.pc",   64'(pc_o),   64'(32'h400));
        check_eq("exc.inst", 64'(inst_o), 64'(32'hDEADBEEF));
        check_eq("exc.tag",  64'(exc_o),  64'(1));
        drive(1'b1, 32'h404, inst_of(32'h404), 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("exc.hold_tag", 64'(exc_o),   64'(1));
        check_eq("exc.hold_cnt", 64'(count_o), 64'(2));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_head("exc_next", 32'h404, 1);
        check_eq("exc_next.tag", 64'(exc_o), 64'(0));
        tick();
        expect_head("exc_empty", 32'h0, 0);
        check_eq("exc_empty.tag", 64'(exc_o), 64'(0));

        // Reset while full beats a simultaneous flush, enqueue and dequeue
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), inst_of(32'h500 + 32'(4 * k)), 1'b0, 1'b1, 1'b0);
            tick();
        end
        expect_head("refill", 32'h500, 4);
        rst = 1'b0;
        drive(1'b1, 32'h600, inst_of(32'h600), 1'b1, 1'b0, 1'b1);
        tick();
        expect_head("mid_reset", 32'h0, 0);
        check_eq("mid_reset.exc", 64'(exc_o), 64'(0));
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_head("after_reset", 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have parameter INST_W, default 32, instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush  input  1  discard all queued entries.
REQ-007 SHALL have port if_valid_i  input  1  IF presents an entry.
REQ-008 SHALL have port pc_i  input  PC_W  fetched PC.
REQ-009 SHALL have port inst_i  input  INST_W  fetched instruction.
REQ-010 SHALL have port exc_i  input  1  fetch-error tag for the entry.
REQ-011 SHALL have port if_ready_o  output  1  queue can accept an entry this cycle.
REQ-012 SHALL have port id_stall  input  1  ID cannot consume the head this cycle.
REQ-013 SHALL have port id_valid_o  output  1  head entry valid.
REQ-014 SHALL have port pc_o  output  PC_W  head PC.
REQ-015 SHALL have port inst_o  output  INST_W  head instruction.
REQ-016 SHALL have port exc_o  output  1  head fetch-error tag.
REQ-017 SHALL have port count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-018 Enqueue SHALL occur when if_valid_i && if_ready_o && !flush; the entry {pc_i, inst_i, exc_i} is written at the tail.
REQ-019 if_ready_o SHALL equal (count_o != DEPTH); it SHALL NOT depend combinationally on id_stall or if_valid_i.
REQ-020 Dequeue SHALL occur when id_valid_o && !id_stall && !flush; head advances by one.
REQ-021 id_valid_o SHALL equal (count_o != 0).
REQ-022 pc_o, inst_o and exc_o SHALL show the head entry when id_valid_o = 1; otherwise they SHALL all be zero (bubble/NOP).
REQ-023 An entry enqueued at edge N SHALL appear on the outputs after edge N when the queue was empty: one-cycle latency.
REQ-024 With id_stall = 1, the head outputs SHALL hold stable; no entry is lost or duplicated.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count_o unchanged and preserve FIFO order.
REQ-026 When full, if_ready_o = 0, so no enqueue occurs, even if a dequeue happens in the same cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or go below 0.
REQ-028 flush = 1 at edge N SHALL set count_o = 0 and both pointers to 0 after edge N; any same-cycle enqueue and dequeue are ignored.
REQ-029 After a flush, outputs SHALL be zero and id_valid_o = 0 until a new entry is enqueued.
REQ-030 Storage contents beyond count_o SHALL NOT be observable on any output.

Reset
REQ-031 rst = 0 at a rising edge SHALL set pointers and count_o to 0; id_valid_o = 0; pc_o, inst_o, exc_o = 0; if_ready_o = 1.
REQ-032 Reset SHALL take priority over flush, enqueue and dequeue, including mid-operation with the queue full.
REQ-033 Storage array contents need not be reset.

Structure
REQ-034 The zero-word and NOP constants and the default PC_W/INST_W values SHALL live in the shared core defines package.
REQ-035 Pointer, count and full/empty logic SHALL be one sub-module, fifo_ctrl, parametrised by DEPTH.
REQ-036 The payload storage SHALL be a register array inside if_id_queue.

Verification
REQ-037 Reset: drive rst = 0 for 2 cycles with if_valid_i = 1 -> count_o = 0, id_valid_o = 0, pc_o = 0, inst_o = 0, if_ready_o = 1.
REQ-038 Fill: DEPTH = 4, id_stall = 1, enqueue PCs 0x100, 0x104, 0x108, 0x10C -> count_o = 4, if_ready_o = 0, pc_o = 0x100 held; a fifth enqueue attempt of 0x110 is dropped.
REQ-039 Drain with wrap: from full, set id_stall = 0 and enqueue 0x110 while dequeuing -> outputs sequence 0x100, 0x104, 0x108, 0x10C, 0x110; count_o never exceeds 4.
REQ-040 Concurrent enqueue/dequeue: count_o = 2, enqueue and dequeue every cycle for 10 cycles -> count_o stays 2 and order is preserved.
REQ-041 Flush: count_o = 3 with flush = 1 and if_valid_i = 1 on the same edge -> next cycle count_o = 0, id_valid_o = 0, inst_o = 0; the next enqueue of 0x200 appears one cycle later.
REQ-042 Exception tag: enqueue inst 0xDEADBEEF with exc_i = 1 -> exc_o = 1 while it is head; exc_o = 0 once the queue empties.
